serial_adder: RTL and testbench

Bit-serial, parametrised successor to the team's one-bit full adder. A single full-adder cell plus a carry flip-flop adds two WIDTH-bit operands LSB-first, one bit per clock, under a start/busy/done handshake. It trades latency for area and serves as the reference multi-cycle arithmetic unit for the datapath blocks that follow.

---
 rtl/serial_adder.sv | 104 ++++++++++
 tb/tb_serial_adder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB-first, start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             done,
  output logic             ovf
`else
  output logic             done
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // state | meaning
  // IDLE  | waiting for start; operands captured on the accepting edge
  // RUN   | one bit per edge; last bit loads sum/cout
  // DONE  | done pulse for one cycle, then back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
  logic [CW-1:0]    cnt;
  logic             carry, s_bit, c_next, last;

  always_comb begin
    s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    c_next   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    res_next = res_sh >> 1;
    res_next[WIDTH-1] = s_bit;
  end

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= c_next;
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum   <= res_next;
            cout  <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on this edge
            ovf   <= carry ^ c_next;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 1, 8 and 16 (table vectors, corner sequences, random ops).
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic        s1 = 0, a1 = 0, b1 = 0, c1 = 0;
  logic        sum1, cout1, busy1, done1;
  logic        s8 = 0, c8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, sum8;
  logic        cout8, busy8, done8;
  logic        s16 = 0, c16 = 0;
  logic [15:0] a16 = 0, b16 = 0, sum16;
  logic        cout16, busy16, done16;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf1, ovf8, ovf16;
`endif

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .cin(c1),
    .sum(sum1), .cout(cout1), .busy(busy1),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf1),
`endif
    .done(done1));

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(c8),
    .sum(sum8), .cout(cout8), .busy(busy8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf8),
`endif
    .done(done8));

  serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16), .cin(c16),
    .sum(sum16), .cout(cout16), .busy(busy16),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf16),
`endif
    .done(done16));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic a, b, ci, s, co;
  } fa_vec_t;

  typedef struct {
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] s;
    logic       co, ov;
  } v8_t;

  typedef struct {
    logic [15:0] a, b;
    logic        ci;
  } op16_t;

  // Runs one WIDTH=8 operation; returns edges from accept to done (41 on timeout).
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic civ, output int lat);
    s8 = 1; a8 = av; b8 = bv; c8 = civ;
    tick();
    s8 = 0;
    lat = 0;
    do begin
      tick();
      lat++;
      chk("excl8", 64'(busy8 & done8), 64'(0));
    end while (!done8 && lat <= 40);
  endtask

  initial begin
    fa_vec_t fa_tab[8];
    v8_t     v8_tab[5];
    op16_t   q16[$];
    op16_t   cur;
    logic [16:0] exp16;
    int lat, last_acc;

    fa_tab = '{'{0,0,0,0,0}, '{0,0,1,1,0}, '{0,1,0,1,0}, '{0,1,1,0,1},
               '{1,0,0,1,0}, '{1,0,1,0,1}, '{1,1,0,0,1}, '{1,1,1,1,1}};
    v8_tab = '{'{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
               '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
               '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
               '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0},
               '{8'h3C, 8'hA5, 1'b1, 8'hE2, 1'b0, 1'b0}};

    // reset state
    tick(); tick();
    chk("rst_sum8", 64'(sum8), 64'(0));
    chk("rst_cout8", 64'(cout8), 64'(0));
    chk("rst_busy8", 64'(busy8), 64'(0));
    chk("rst_done8", 64'(done8), 64'(0));
    chk("rst_sum16", 64'(sum16), 64'(0));
    chk("rst_busy1", 64'(busy1), 64'(0));
    @(negedge clk);
    rst_n = 1;
    tick();

    // WIDTH=1 full-adder truth table
    for (int i = 0; i < 8; i++) begin
      s1 = 1; a1 = fa_tab[i].a; b1 = fa_tab[i].b; c1 = fa_tab[i].ci;
      tick();
      s1 = 0;
      chk("w1_busy", 64'(busy1), 64'(1));
      chk("w1_done_early", 64'(done1), 64'(0));
      tick();
      chk("w1_done", 64'(done1), 64'(1));
      chk("w1_busy_off", 64'(busy1), 64'(0));
      chk("w1_sum", 64'(sum1), 64'(fa_tab[i].s));
      chk("w1_cout", 64'(cout1), 64'(fa_tab[i].co));
      tick();
      chk("w1_done_fall", 64'(done1), 64'(0));
    end

    // WIDTH=8 directed vectors
    for (int i = 0; i < 5; i++) begin
      op8(v8_tab[i].a, v8_tab[i].b, v8_tab[i].ci, lat);
      chk("w8_lat", 64'(lat), 64'(8));
      chk("w8_sum", 64'(sum8), 64'(v8_tab[i].s));
      chk("w8_cout", 64'(cout8), 64'(v8_tab[i].co));
`ifdef SERIAL_ADDER_OVF_EN
      chk("w8_ovf", 64'(ovf8), 64'(v8_tab[i].ov));
`endif
      tick();
      chk("w8_done_fall", 64'(done8), 64'(0));
    end

    // start held during busy with changed operands: ignored, not queued
    op8(8'h00, 8'h00, 1'b0, lat);
    tick();
    s8 = 1; a8 = 8'h3C; b8 = 8'hA5; c8 = 1;
    tick();
    a8 = 8'h11; b8 = 8'h22; c8 = 0;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 2) begin
        chk("ign_busy", 64'(busy8), 64'(1));
        chk("ign_sum_hold", 64'(sum8), 64'(8'h00));
      end
      if (lat == 3) s8 = 0;
    end while (!done8 && lat <= 40);
    chk("ign_lat", 64'(lat), 64'(8));
    chk("ign_sum", 64'(sum8), 64'(8'hE2));
    chk("ign_cout", 64'(cout8), 64'(0));
    tick();
    chk("ign_done_fall", 64'(done8), 64'(0));
    tick();
    chk("ign_noqueue", 64'(busy8), 64'(0));
    chk("ign_sum_held", 64'(sum8), 64'(8'hE2));

    // reset mid-operation
    s8 = 1; a8 = 8'hFF; b8 = 8'hFF; c8 = 0;
    tick();
    s8 = 0;
    tick(); tick(); tick();
    chk("mid_busy_pre", 64'(busy8), 64'(1));
    rst_n = 0;
    #1;
    chk("mid_busy", 64'(busy8), 64'(0));
    chk("mid_done", 64'(done8), 64'(0));
    chk("mid_sum", 64'(sum8), 64'(0));
    chk("mid_cout", 64'(cout8), 64'(0));
    tick();
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("mid_no_done", 64'(done8), 64'(0));
    op8(8'h01, 8'h02, 1'b0, lat);
    chk("post_lat", 64'(lat), 64'(8));
    chk("post_sum", 64'(sum8), 64'(8'h03));
    chk("post_cout", 64'(cout8), 64'(0));
    tick();

    // WIDTH=16 random back-to-back with start held high
    last_acc = 0;
    cur.a = 16'($urandom()); cur.b = 16'($urandom()); cur.ci = 1'($urandom_range(0, 1));
    q16.push_back(cur);
    s16 = 1; a16 = cur.a; b16 = cur.b; c16 = cur.ci;
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("r16_accept", 64'(busy16), 64'(1));
      if (i > 0) chk("r16_spacing", 64'(cyc - last_acc), 64'(18));
      last_acc = cyc;
      lat = 0;
      do begin
        tick();
        lat++;
        chk("excl16", 64'(busy16 & done16), 64'(0));
      end while (!done16 && lat <= 40);
      chk("r16_lat", 64'(lat), 64'(16));
      if (q16.size() > 0) begin
        cur = q16.pop_front();
        exp16 = {1'b0, cur.a} + {1'b0, cur.b} + 17'(cur.ci);
        chk("r16_sum", 64'(sum16), 64'(exp16[15:0]));
        chk("r16_cout", 64'(cout16), 64'(exp16[16]));
`ifdef SERIAL_ADDER_OVF_EN
        chk("r16_ovf", 64'(ovf16),
            64'((cur.a[15] == cur.b[15]) && (exp16[15] != cur.a[15])));
`endif
      end
      if (i < 199) begin
        cur.a = 16'($urandom()); cur.b = 16'($urandom()); cur.ci = 1'($urandom_range(0, 1));
        q16.push_back(cur);
        a16 = cur.a; b16 = cur.b; c16 = cur.ci;
      end else begin
        s16 = 0;
      end
      tick();
      chk("r16_done_fall", 64'(done16), 64'(0));
      chk("r16_no_accept_in_done", 64'(busy16), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
